// File: rtl/inv_arbiter.sv
// ---------------------------------------------------------------------------
// inv_arbiter
//
// Shares a single sequential fixed-point reciprocal unit among N_REQ
// requesters. One request is accepted at a time using round-robin priority.
// The accepted operand is launched into the unit, the unit's done pulse is
// awaited, and the result is returned with the requester index over one
// valid/ready response channel.
//
// Ports
//   clk, rst_n        system clock, synchronous active-low reset
//   req_valid[i]      requester i has an operand pending
//   req_ready[i]      accept strobe, one-hot or zero, only while idle
//   req_x             packed operands, requester i at [i*IN_BITS +: IN_BITS]
//   rsp_valid/ready   response handshake
//   rsp_id            index of the requester the response belongs to
//   rsp_y             signed Q0.OUT_FBITS reciprocal (0 when unit not valid)
//   rsp_dbz, rsp_ovf  divide-by-zero / overflow flags from the unit
//   busy              high whenever an operation is in flight
//   inv_start         one-cycle launch pulse to the reciprocal unit
//   inv_x             operand presented to the unit, stable until done
//   inv_busy          unit busy; launch is held off while high
//   inv_done          unit completion pulse, only honoured while waiting
//   inv_valid         unit result valid
//   inv_dbz, inv_ovf  unit flags
//   inv_y             unit result
// ---------------------------------------------------------------------------
module inv_arbiter #(
  parameter  int N_REQ     = 4,
  parameter  int IN_BITS   = 64,
  parameter  int OUT_FBITS = 32,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*IN_BITS-1:0] req_x,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [OUT_FBITS-1:0]     rsp_y,
  output logic                     rsp_dbz,
  output logic                     rsp_ovf,
  output logic                     busy,
  output logic                     inv_start,
  output logic [IN_BITS-1:0]       inv_x,
  input  logic                     inv_busy,
  input  logic                     inv_done,
  input  logic                     inv_valid,
  input  logic                     inv_dbz,
  input  logic                     inv_ovf,
  input  logic [OUT_FBITS-1:0]     inv_y
);

  localparam int unsigned NR = N_REQ;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        ptr_q,   ptr_d;
  logic [ID_W-1:0]        id_q,    id_d;
  logic [IN_BITS-1:0]     x_q,     x_d;
  logic [OUT_FBITS-1:0]   y_q,     y_d;
  logic                   dbz_q,   dbz_d;
  logic                   ovf_q,   ovf_d;

  logic                   grant_vld;
  logic [ID_W-1:0]        grant_idx;
  logic [IN_BITS-1:0]     grant_x;

  // -------------------------------------------------------------------------
  // Round-robin search: first valid requester starting at ptr_q, wrapping
  // modulo N_REQ. The first hit wins, later candidates are ignored.
  // -------------------------------------------------------------------------
  always_comb begin : rr_search
    logic [ID_W-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      cand = ID_W'((32'(ptr_q) + k) % NR);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_x = req_x[grant_idx*IN_BITS +: IN_BITS];
  end

  // Accept strobe is combinational so the handshake completes in the same
  // cycle the request is seen while idle.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    x_d       = x_q;
    y_d       = y_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    inv_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          id_d    = grant_idx;
          x_d     = grant_x;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // Launch only once the unit is free; the pulse is a single cycle
        // because the state leaves ISSUE on the same edge.
        if (!inv_busy) begin
          inv_start = 1'b1;
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        if (inv_done) begin
          y_d     = inv_valid ? inv_y : '0;
          dbz_d   = inv_dbz;
          ovf_d   = inv_ovf;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          // Priority moves to the requester after the one just served.
          ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs straight from state / registers.
  // -------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q != S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_id    = id_q;
    rsp_y     = y_q;
    rsp_dbz   = dbz_q;
    rsp_ovf   = ovf_q;
    inv_x     = x_q;
  end

endmodule

// File: tb/tb_inv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_inv_arbiter
//
// Directed bench for inv_arbiter. A small behavioural reciprocal unit with a
// fixed latency sits behind the arbiter; inj_busy / inj_done let the bench
// hold the unit busy or inject a stray done pulse.
// ---------------------------------------------------------------------------
module tb_inv_arbiter;

  localparam int N  = 4;
  localparam int IB = 64;
  localparam int OB = 32;
  localparam int IW = 2;
  localparam int L  = 4;

  localparam longint YMAX = 64'sh0000_0000_7FFF_FFFF;
  localparam longint YMIN = -64'sh0000_0000_8000_0000;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*IB-1:0] req_x;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [OB-1:0]   rsp_y;
  logic            rsp_dbz;
  logic            rsp_ovf;
  logic            busy;
  logic            inv_start;
  logic [IB-1:0]   inv_x;
  logic            inv_busy;
  logic            inv_done;
  logic            inv_valid;
  logic            inv_dbz;
  logic            inv_ovf;
  logic [OB-1:0]   inv_y;

  logic            m_busy, m_done, m_valid, m_dbz, m_ovf;
  logic [OB-1:0]   m_y;
  logic [IB-1:0]   m_x;
  int              m_cnt;
  logic            inj_busy, inj_done;
  logic            hold_all;

  int              errs, checks;
  int              cyc, start_cnt, rdy0_cnt;
  int              start_cyc[$];
  int              grant_log[$];

  inv_arbiter #(.N_REQ(N), .IN_BITS(IB), .OUT_FBITS(OB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_dbz(rsp_dbz), .rsp_ovf(rsp_ovf), .busy(busy),
    .inv_start(inv_start), .inv_x(inv_x), .inv_busy(inv_busy),
    .inv_done(inv_done), .inv_valid(inv_valid), .inv_dbz(inv_dbz),
    .inv_ovf(inv_ovf), .inv_y(inv_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reciprocal unit: y = 2^32 / x ----------------
  function automatic logic [OB-1:0] ref_y(input longint x);
    longint q;
    q = 64'sh0000_0001_0000_0000 / x;
    return q[OB-1:0];
  endfunction

  function automatic logic ref_ovf(input longint x);
    longint q;
    q = 64'sh0000_0001_0000_0000 / x;
    return (q > YMAX) || (q < YMIN);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_valid <= 1'b0;
      m_dbz  <= 1'b0; m_ovf  <= 1'b0; m_y     <= '0;
      m_x    <= '0;   m_cnt  <= 0;
    end else begin
      m_done <= 1'b0;
      if (inv_start && !m_busy) begin
        m_busy <= 1'b1;
        m_cnt  <= L;
        m_x    <= inv_x;
      end else if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          if (m_x == '0) begin
            m_valid <= 1'b0; m_dbz <= 1'b1; m_ovf <= 1'b0;
            m_y     <= 32'hDEAD_BEEF;
          end else begin
            m_valid <= 1'b1; m_dbz <= 1'b0;
            m_ovf   <= ref_ovf(longint'(m_x));
            m_y     <= ref_y(longint'(m_x));
          end
        end
      end
    end
  end

  assign inv_busy  = m_busy | inj_busy;
  assign inv_done  = m_done | inj_done;
  assign inv_valid = m_done ? m_valid : inj_done;
  assign inv_y     = m_done ? m_y : 32'h1234_5678;
  assign inv_dbz   = m_done & m_dbz;
  assign inv_ovf   = m_done & m_ovf;

  // ---------------- monitor (negedge, away from the active edge) ------------
  initial begin
    cyc = 0; start_cnt = 0; rdy0_cnt = 0;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (inv_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc.push_back(cyc);
    end
    if (req_ready[0]) rdy0_cnt <= rdy0_cnt + 1;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) grant_log.push_back(i);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; requesters drop req_valid after their handshake
  // unless hold_all keeps everyone requesting.
  task automatic tick();
    logic [N-1:0] hs;
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    if (!hold_all) req_valid = req_valid & ~hs;
  endtask

  task automatic set_x(input int i, input logic [IB-1:0] v);
    req_x[i*IB +: IB] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic get_rsp(output int id, output logic [OB-1:0] y,
                         output logic dbz, output logic ovf);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    if (!rsp_valid) check("rsp_timeout", {63'd0, rsp_valid}, 64'd1);
    id  = int'(rsp_id);
    y   = rsp_y;
    dbz = rsp_dbz;
    ovf = rsp_ovf;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int            id, s0, r0, g0, sc, n;
    logic [OB-1:0] y;
    logic          dbz, ovf;
    logic [OB-1:0] fair_y [N];

    errs = 0; checks = 0;
    rst_n = 1'b0; req_valid = '0; req_x = '0; rsp_ready = 1'b1;
    inj_busy = 1'b0; inj_done = 1'b0; hold_all = 1'b0;

    // reset state
    do_reset();
    check("rst_outs", {21'd0, req_ready, rsp_valid, rsp_id, rsp_y, rsp_dbz,
                       rsp_ovf, inv_start, busy}, 64'd0);
    check("rst_inv_x", inv_x, 64'd0);

    // single op, requester 0, x=4
    s0 = start_cnt; r0 = rdy0_cnt;
    set_x(0, 64'd4); req_valid = 4'b0001; #1;
    check("single_ready", {60'd0, req_ready}, 64'b0001);
    tick();
    check("single_issue", {58'd0, inv_start, busy, req_ready}, {58'd0, 2'b11, 4'b0000});
    check("single_inv_x", inv_x, 64'd4);
    get_rsp(id, y, dbz, ovf);
    check("single_id", id, 0);
    check("single_y", y, 32'h4000_0000);
    check("single_flags", {dbz, ovf}, 2'b00);
    check("single_starts", start_cnt - s0, 1);
    check("single_ready_cycles", rdy0_cnt - r0, 1);
    check("single_idle", {busy, rsp_valid}, 2'b00);

    // divide by zero, requester 2
    set_x(2, 64'd0); req_valid = 4'b0100; #1;
    get_rsp(id, y, dbz, ovf);
    check("dbz_id", id, 2);
    check("dbz_y", y, 0);
    check("dbz_flags", {dbz, ovf}, 2'b10);
    check("dbz_idle", {busy, rsp_valid}, 2'b00);

    // contention: 0 and 2 together after reset
    do_reset();
    s0 = start_cyc.size();
    set_x(0, 64'd2); set_x(2, -64'sd8); req_valid = 4'b0101; #1;
    get_rsp(id, y, dbz, ovf);
    check("cont_id0", id, 0);
    check("cont_y0", y, 32'h8000_0000);
    get_rsp(id, y, dbz, ovf);
    check("cont_id1", id, 2);
    check("cont_y1", y, 32'hE000_0000);
    check("cont_flags1", {dbz, ovf}, 2'b00);
    check("cont_starts", start_cyc.size() - s0, 2);
    check("cont_spacing", {63'd0, (start_cyc[s0+1] - start_cyc[s0]) >= L + 3}, 64'd1);

    // fairness: all four requesting continuously for 8 ops
    do_reset();
    fair_y[0] = 32'h4000_0000; fair_y[1] = 32'h2000_0000;
    fair_y[2] = 32'h1000_0000; fair_y[3] = 32'hC000_0000;
    set_x(0, 64'd4); set_x(1, 64'd8); set_x(2, 64'd16); set_x(3, -64'sd4);
    g0 = grant_log.size();
    hold_all = 1'b1; req_valid = 4'b1111; #1;
    for (int i = 0; i < 8; i++) begin
      get_rsp(id, y, dbz, ovf);
      check("fair_id", id, i % N);
      check("fair_y", y, fair_y[i % N]);
    end
    req_valid = '0; hold_all = 1'b0; #1;
    check("fair_grants", grant_log.size() - g0, 8);
    for (int i = 0; i < 8; i++) check("fair_grant_order", grant_log[g0+i], i % N);

    // issue held while unit busy, then response backpressure
    rsp_ready = 1'b0; inj_busy = 1'b1;
    set_x(1, 64'd8); req_valid = 4'b0010; #1;
    tick();
    check("hold_issue", {inv_start, busy}, 2'b01);
    s0 = start_cnt;
    tick(); tick();
    check("hold_still", {inv_start, busy}, 2'b01);
    inj_busy = 1'b0; #1;
    check("hold_release", inv_start, 1);
    n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    check("bp_rsp_seen", rsp_valid, 1);
    set_x(2, 64'd16); req_valid = 4'b0100; #1;
    sc = start_cnt;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {rsp_valid, rsp_id, rsp_y, rsp_dbz, rsp_ovf, req_ready},
            {1'b1, 2'd1, 32'h2000_0000, 2'b00, 4'b0000});
      tick();
    end
    check("bp_no_start", start_cnt - sc, 0);
    check("hold_one_start", sc - s0, 1);
    rsp_ready = 1'b1; #1;
    tick();
    check("bp_accept", {rsp_valid, busy, req_ready}, {2'b00, 4'b0100});
    get_rsp(id, y, dbz, ovf);
    check("bp_next_id", id, 2);
    check("bp_next_y", y, 32'h1000_0000);

    // reset while waiting; ptr is 3 at this point
    set_x(1, 64'd4); req_valid = 4'b0010; #1;
    tick(); tick();
    check("rw_in_wait", {inv_start, busy}, 2'b01);
    rst_n = 1'b0;
    tick();
    check("rw_outs", {21'd0, req_ready, rsp_valid, rsp_id, rsp_y, rsp_dbz,
                      rsp_ovf, inv_start, busy}, 64'd0);
    check("rw_inv_x", inv_x, 64'd0);
    rst_n = 1'b1; inj_done = 1'b1; #1;
    tick();
    inj_done = 1'b0; #1;
    check("rw_stale_done", {rsp_valid, busy}, 2'b00);
    tick(); tick();
    check("rw_stale_later", {rsp_valid, busy}, 2'b00);
    req_valid = 4'b1100; #1;
    check("rw_ptr", {60'd0, req_ready}, 64'b0100);
    get_rsp(id, y, dbz, ovf);
    check("rw_id", id, 2);
    req_valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/inv_arbiter.md
Name: inv_arbiter

Overview:
Shares one sequential fixed-point reciprocal unit (start/busy/done handshake, Q0.OUT_FBITS result) among N_REQ requesters. Accepts one request at a time with round-robin priority, launches the unit, and returns the result with a requester ID over a single valid/ready response channel. Sits between the geometry/shading clients and the single reciprocal instance, so only one divider is instantiated.

Parameters:
N_REQ, 4, number of requesters (2..8)
IN_BITS, 64, operand width, equals the reciprocal unit input width
OUT_FBITS, 32, result width / fractional bits, equals the reciprocal unit output width
ID_W, $clog2(N_REQ), requester ID width (derived localparam)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept, one-hot or zero
req_x  in  N_REQ*IN_BITS  packed signed operands, requester i at bits [i*IN_BITS +: IN_BITS]
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  requester index of response
rsp_y  out  OUT_FBITS  signed reciprocal result
rsp_dbz  out  1  divide-by-zero flag
rsp_ovf  out  1  overflow flag
busy  out  1  high whenever state != IDLE
inv_start  out  1  one-cycle start pulse to reciprocal unit
inv_x  out  IN_BITS  operand to reciprocal unit
inv_busy  in  1  unit busy
inv_done  in  1  unit done pulse
inv_valid  in  1  result valid
inv_dbz  in  1  unit divide-by-zero
inv_ovf  in  1  unit overflow
inv_y  in  OUT_FBITS  unit result

Behaviour:
- Clock is clk; reset is synchronous, active-low (rst_n sampled on rising edge of clk).
- Reset: state=IDLE, ptr=0, latched operand/ID/result regs=0; req_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_dbz=0, rsp_ovf=0, inv_start=0, inv_x=0, busy=0. Reset mid-operation aborts immediately and drops any pending response.
- The reciprocal unit must share this reset. Any inv_done seen outside WAIT is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = first i with req_valid[i], searching ptr, ptr+1, ... with modulo-N_REQ wrap.
  - req_ready[grant] is combinationally high, all other bits are 0. req_ready is all 0 in every other state.
  - On handshake: latch req_x[grant] into inv_x and grant into the ID register, then go to ISSUE.
  - With no req_valid: stay in IDLE.
- ISSUE: inv_start=1 for exactly one cycle if inv_busy=0, then go to WAIT. If inv_busy=1, hold in ISSUE with inv_start=0.
- WAIT: inv_x held stable. On inv_done:
  - capture rsp_y = inv_valid ? inv_y : 0
  - capture rsp_dbz = inv_dbz
  - capture rsp_ovf = inv_ovf
  - go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/rsp_y/rsp_dbz/rsp_ovf stable until accepted.
  - On rsp_valid & rsp_ready: ptr = (id+1) mod N_REQ, then go to IDLE.
  - No new request is accepted in the same cycle.
- Latency: handshake at edge T → inv_start in cycle T+1 → inv_done in cycle T+1+L (L = unit latency) → rsp_valid from cycle T+2+L. Minimum occupancy per op is L+3 cycles.
- A requester must hold req_valid and req_x until its req_ready handshake. Deasserting req_valid before grant is allowed; that requester is skipped.
- Fairness: a continuously requesting client waits at most N_REQ-1 other operations.
- busy = (state != IDLE).

Test Plan:
- Single op: req_valid=0001, x=4 → one inv_start pulse; rsp_id=0, rsp_y=0x40000000, dbz=0, ovf=0; req_ready[0] high exactly one cycle.
- Divide by zero: requester 2, x=0 → rsp_id=2, rsp_dbz=1, rsp_y=0, then return to IDLE with busy=0.
- Contention: requesters 0 and 2 assert together with x=2 and x=-8 after reset → response order id0 (0x80000000 bit pattern per unit) then id2 (y=0xE0000000); inv_start pulses spaced ≥ L+3 cycles.
- Fairness: all four requesters held valid for 8 ops → grant order 0,1,2,3,0,1,2,3; no requester granted twice before the others.
- Backpressure: rsp_ready low 5 cycles in RESP → rsp_* stable, req_ready=0, no inv_start; accepted on the 6th cycle.
- Reset mid-WAIT: rst_n=0 for one cycle during WAIT → next cycle all outputs 0, state IDLE, ptr=0; a stale inv_done afterwards produces no rsp_valid.
